// File: rtl/axi4_burst_addr_gen_pkg.sv
// Shared AXI4 encodings and helpers for the burst address generator.
package axi4_burst_addr_gen_pkg;

  localparam logic [2:0] AXI4_SIZE_1B   = 3'd0;
  localparam logic [2:0] AXI4_SIZE_2B   = 3'd1;
  localparam logic [2:0] AXI4_SIZE_4B   = 3'd2;
  localparam logic [2:0] AXI4_SIZE_8B   = 3'd3;
  localparam logic [2:0] AXI4_SIZE_16B  = 3'd4;
  localparam logic [2:0] AXI4_SIZE_32B  = 3'd5;
  localparam logic [2:0] AXI4_SIZE_64B  = 3'd6;
  localparam logic [2:0] AXI4_SIZE_128B = 3'd7;

  localparam logic [1:0] AXI4_BURST_FIXED = 2'd0;
  localparam logic [1:0] AXI4_BURST_INCR  = 2'd1;
  localparam logic [1:0] AXI4_BURST_WRAP  = 2'd2;
  localparam logic [1:0] AXI4_BURST_RSVD  = 2'd3;

  typedef logic [7:0] axi4_len_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } axi4_agen_state_t;

  function automatic logic [7:0] axi4_size_bytes(input logic [2:0] size);
    return 8'd1 << size;
  endfunction

endpackage

// File: rtl/axi4_burst_addr_gen_strb_gen.sv
// Combinational byte-lane mask from a beat's address offset and AxSIZE.
module axi4_strb_gen
  import axi4_burst_addr_gen_pkg::*;
#(
  parameter int NBYTES = 8,
  localparam int LOG2 = $clog2(NBYTES),
  localparam int OFFW = (LOG2 > 0) ? LOG2 : 1
) (
  input  logic [OFFW-1:0]   off,
  input  logic [2:0]        size,
  output logic [NBYTES-1:0] strb
);

  localparam int OW1 = OFFW + 1;

  logic [OW1-1:0]  bytes_s;
  logic [OFFW-1:0] aligned_s;
  logic [OW1-1:0]  end_s;

  // Lanes from the start offset up to the end of the size-aligned container.
  always_comb begin
    strb      = '0;
    bytes_s   = OW1'(1) << size;
    aligned_s = off & ~(bytes_s[OFFW-1:0] - OFFW'(1));
    end_s     = {1'b0, aligned_s} + bytes_s;
    if (size >= 3'(LOG2)) begin
      strb = '1;
    end else begin
      for (int i = 0; i < NBYTES; i++) begin
        strb[i] = (OW1'(i) >= {1'b0, off}) && (OW1'(i) < end_s);
      end
    end
  end

endmodule

// File: rtl/axi4_burst_addr_gen.sv
// Expands one AXI4 AW/AR request into per-beat address/strobe/last/idx.
// Optional burst legality flagging is built when AXI4_ADDR_GEN_LEGAL_CHECK_EN is defined.
module axi4_burst_addr_gen
  import axi4_burst_addr_gen_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 8,
  localparam int NBYTES = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic [2:0]            req_size,
  input  logic [1:0]            req_burst,
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic [ADDR_WIDTH-1:0] beat_addr,
  output logic [NBYTES-1:0]     beat_strb,
  output logic [LEN_WIDTH-1:0]  beat_idx,
  output logic                  beat_last,
  output logic                  beat_err
);

  localparam int LOG2 = $clog2(NBYTES);
  localparam int OFFW = (LOG2 > 0) ? LOG2 : 1;

  axi4_agen_state_t      state_q, state_d;
  logic [ADDR_WIDTH-1:0] beat_addr_q, beat_addr_d;
  logic [NBYTES-1:0]     beat_strb_q, beat_strb_d;
  logic [LEN_WIDTH-1:0]  beat_idx_q, beat_idx_d;
  logic                  beat_last_q, beat_last_d;
  logic                  beat_err_q, beat_err_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [ADDR_WIDTH-1:0] wrap_lower_q, wrap_lower_d;
  logic [ADDR_WIDTH-1:0] wrap_bound_q, wrap_bound_d;

  logic                  accept_s;
  logic                  fire_s;
  logic                  illegal_s;
  logic [ADDR_WIDTH-1:0] bytes_s;
  logic [ADDR_WIDTH-1:0] incr_s;
  logic [ADDR_WIDTH-1:0] next_addr_s;
  logic [ADDR_WIDTH-1:0] req_bytes_s;
  logic [ADDR_WIDTH-1:0] req_span_s;
  logic [ADDR_WIDTH-1:0] req_lower_s;
  logic [LEN_WIDTH-1:0]  idx_inc_s;
  logic [NBYTES-1:0]     strb_s;

  assign fire_s    = (state_q == BURST) & beat_ready;
  assign req_ready = (state_q == IDLE) | (fire_s & beat_last_q);
  assign accept_s  = req_valid & req_ready;

  assign req_bytes_s = ADDR_WIDTH'(axi4_size_bytes(req_size));
  assign req_span_s  = (ADDR_WIDTH'(req_len) + ADDR_WIDTH'(1)) << req_size;
  assign req_lower_s = req_addr & ~(req_span_s - ADDR_WIDTH'(1));
  assign idx_inc_s   = beat_idx_q + LEN_WIDTH'(1);

`ifdef AXI4_ADDR_GEN_LEGAL_CHECK_EN
  logic [ADDR_WIDTH-1:0] req_last_addr_s;
  logic                  wrap_len_ok_s;

  assign req_last_addr_s = (req_addr & ~(req_bytes_s - ADDR_WIDTH'(1)))
                         + (ADDR_WIDTH'(req_len) << req_size);
  assign wrap_len_ok_s   = (req_len == LEN_WIDTH'(1)) | (req_len == LEN_WIDTH'(3)) |
                           (req_len == LEN_WIDTH'(7)) | (req_len == LEN_WIDTH'(15));

  // Burst legality evaluated against the request being accepted.
  always_comb begin
    illegal_s = 1'b0;
    if ((req_burst == AXI4_BURST_INCR) &&
        (req_last_addr_s[ADDR_WIDTH-1:12] != req_addr[ADDR_WIDTH-1:12])) begin
      illegal_s = 1'b1;
    end else if ((req_burst == AXI4_BURST_WRAP) &&
                 (!wrap_len_ok_s || ((req_addr & (req_bytes_s - ADDR_WIDTH'(1))) != '0))) begin
      illegal_s = 1'b1;
    end else if ((req_size > 3'(LOG2)) || (req_burst == AXI4_BURST_RSVD)) begin
      illegal_s = 1'b1;
    end else begin
      illegal_s = 1'b0;
    end
  end
`else
  assign illegal_s = 1'b0;
`endif

  // Address of the following beat for the burst in flight.
  always_comb begin
    bytes_s     = ADDR_WIDTH'(axi4_size_bytes(size_q));
    incr_s      = (beat_addr_q & ~(bytes_s - ADDR_WIDTH'(1))) + bytes_s;
    next_addr_s = incr_s;
    case (burst_q)
      AXI4_BURST_FIXED: next_addr_s = beat_addr_q;
      AXI4_BURST_WRAP:  next_addr_s = (incr_s == wrap_bound_q) ? wrap_lower_q : incr_s;
      default:          next_addr_s = incr_s;
    endcase
  end

  // Next-state: load a new burst on accept, advance on beat handshake, else hold.
  always_comb begin
    state_d      = state_q;
    beat_addr_d  = beat_addr_q;
    beat_idx_d   = beat_idx_q;
    beat_last_d  = beat_last_q;
    beat_err_d   = beat_err_q;
    len_d        = len_q;
    size_d       = size_q;
    burst_d      = burst_q;
    wrap_lower_d = wrap_lower_q;
    wrap_bound_d = wrap_bound_q;
    if (accept_s) begin
      state_d      = BURST;
      beat_addr_d  = req_addr;
      beat_idx_d   = '0;
      beat_last_d  = (req_len == '0);
      beat_err_d   = illegal_s;
      len_d        = req_len;
      size_d       = req_size;
      burst_d      = req_burst;
      wrap_lower_d = req_lower_s;
      wrap_bound_d = req_lower_s + req_span_s;
    end else if (fire_s && beat_last_q) begin
      state_d = IDLE;
    end else if (fire_s) begin
      beat_addr_d = next_addr_s;
      beat_idx_d  = idx_inc_s;
      beat_last_d = (idx_inc_s == len_q);
    end else begin
      state_d = state_q;
    end
    beat_strb_d = strb_s;
  end

  axi4_strb_gen #(.NBYTES(NBYTES)) u_strb_gen (
    .off  (beat_addr_d[OFFW-1:0]),
    .size (size_d),
    .strb (strb_s)
  );

  // State and beat output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_addr_q  <= '0;
      beat_strb_q  <= '0;
      beat_idx_q   <= '0;
      beat_last_q  <= 1'b0;
      beat_err_q   <= 1'b0;
      len_q        <= '0;
      size_q       <= 3'd0;
      burst_q      <= 2'd0;
      wrap_lower_q <= '0;
      wrap_bound_q <= '0;
    end else begin
      state_q      <= state_d;
      beat_addr_q  <= beat_addr_d;
      beat_strb_q  <= beat_strb_d;
      beat_idx_q   <= beat_idx_d;
      beat_last_q  <= beat_last_d;
      beat_err_q   <= beat_err_d;
      len_q        <= len_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      wrap_lower_q <= wrap_lower_d;
      wrap_bound_q <= wrap_bound_d;
    end
  end

  assign beat_valid = (state_q == BURST);
  assign beat_addr  = beat_addr_q;
  assign beat_strb  = beat_strb_q;
  assign beat_idx   = beat_idx_q;
  assign beat_last  = beat_last_q;
  assign beat_err   = beat_err_q;

endmodule

// File: tb/tb_axi4_burst_addr_gen.sv
// Directed self-checking bench for axi4_burst_addr_gen (DATA_WIDTH=64).
module tb_axi4_burst_addr_gen;

  localparam int AW = 32;
  localparam int LW = 8;
  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic [2:0]    req_size;
  logic [1:0]    req_burst;
  logic          beat_valid;
  logic          beat_ready;
  logic [AW-1:0] beat_addr;
  logic [NB-1:0] beat_strb;
  logic [LW-1:0] beat_idx;
  logic          beat_last;
  logic          beat_err;

  int   n_checks = 0;
  int   n_pass   = 0;
  logic legal_en;

  axi4_burst_addr_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(64), .LEN_WIDTH(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .req_size   (req_size),
    .req_burst  (req_burst),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .beat_addr  (beat_addr),
    .beat_strb  (beat_strb),
    .beat_idx   (beat_idx),
    .beat_last  (beat_last),
    .beat_err   (beat_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [LW-1:0] l,
                      input logic [2:0] s, input logic [1:0] b);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    req_size  = s;
    req_burst = b;
    #1;
    check_val("req_ready_at_accept", 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [AW-1:0] a, input logic [NB-1:0] st,
                      input logic [LW-1:0] i, input logic l, input logic e);
    check_val({tag, "_valid"}, 64'(beat_valid), 64'd1);
    check_val({tag, "_addr"},  64'(beat_addr),  64'(a));
    check_val({tag, "_strb"},  64'(beat_strb),  64'(st));
    check_val({tag, "_idx"},   64'(beat_idx),   64'(i));
    check_val({tag, "_last"},  64'(beat_last),  64'(l));
    check_val({tag, "_err"},   64'(beat_err),   64'(e));
  endtask

  task automatic expect_idle(input string tag);
    check_val({tag, "_idle_valid"}, 64'(beat_valid), 64'd0);
    check_val({tag, "_idle_ready"}, 64'(req_ready),  64'd1);
  endtask

  initial begin
`ifdef AXI4_ADDR_GEN_LEGAL_CHECK_EN
    legal_en = 1'b1;
`else
    legal_en = 1'b0;
`endif
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = 32'h0;
    req_len    = 8'h0;
    req_size   = 3'd0;
    req_burst  = 2'd0;
    beat_ready = 1'b1;
    #12;
    check_val("rst_valid", 64'(beat_valid), 64'd0);
    check_val("rst_addr",  64'(beat_addr),  64'd0);
    check_val("rst_strb",  64'(beat_strb),  64'd0);
    check_val("rst_idx",   64'(beat_idx),   64'd0);
    check_val("rst_last",  64'(beat_last),  64'd0);
    check_val("rst_err",   64'(beat_err),   64'd0);
    check_val("rst_ready", 64'(req_ready),  64'd1);
    rst = 1'b0;
    step();

    // INCR 8B aligned
    send(32'h1000, 8'd3, 3'd3, 2'd1);
    for (int i = 0; i < 4; i++) begin
      beat("incr", 32'h1000 + 32'(8 * i), 8'hFF, 8'(i), (i == 3), 1'b0);
      step();
    end
    expect_idle("incr");

    // WRAP 4B: 0x1034,0x1038,0x103C,0x1030
    send(32'h1034, 8'd3, 3'd2, 2'd2);
    beat("wrap0", 32'h1034, 8'hF0, 8'd0, 1'b0, 1'b0); step();
    beat("wrap1", 32'h1038, 8'h0F, 8'd1, 1'b0, 1'b0); step();
    beat("wrap2", 32'h103C, 8'hF0, 8'd2, 1'b0, 1'b0); step();
    beat("wrap3", 32'h1030, 8'h0F, 8'd3, 1'b1, 1'b0); step();
    expect_idle("wrap");

    // INCR unaligned start
    send(32'h2003, 8'd1, 3'd2, 2'd1);
    beat("unal0", 32'h2003, 8'h08, 8'd0, 1'b0, 1'b0); step();
    beat("unal1", 32'h2004, 8'hF0, 8'd1, 1'b1, 1'b0); step();
    expect_idle("unal");

    // Back-to-back bursts
    send(32'h3000, 8'd1, 3'd3, 2'd1);
    beat("b2b_a0", 32'h3000, 8'hFF, 8'd0, 1'b0, 1'b0);
    check_val("b2b_ready_midburst", 64'(req_ready), 64'd0);
    step();
    beat("b2b_a1", 32'h3008, 8'hFF, 8'd1, 1'b1, 1'b0);
    send(32'h4000, 8'd0, 3'd3, 2'd1);
    beat("b2b_b0", 32'h4000, 8'hFF, 8'd0, 1'b1, 1'b0); step();
    expect_idle("b2b");

    // FIXED with stalls: beat_ready 1,0,0,1,1
    send(32'h40, 8'd2, 3'd3, 2'd0);
    beat("fix0", 32'h40, 8'hFF, 8'd0, 1'b0, 1'b0); step();
    beat_ready = 1'b0;
    beat("fix1", 32'h40, 8'hFF, 8'd1, 1'b0, 1'b0);
    check_val("fix_stall_ready", 64'(req_ready), 64'd0);
    step();
    beat("fix1_hold1", 32'h40, 8'hFF, 8'd1, 1'b0, 1'b0); step();
    beat("fix1_hold2", 32'h40, 8'hFF, 8'd1, 1'b0, 1'b0);
    beat_ready = 1'b1;
    step();
    beat("fix2", 32'h40, 8'hFF, 8'd2, 1'b1, 1'b0); step();
    expect_idle("fix");

    // size wider than bus: full strobe, 16B step, flagged when checking
    send(32'h100, 8'd1, 3'd4, 2'd1);
    beat("wide0", 32'h100, 8'hFF, 8'd0, 1'b0, legal_en); step();
    beat("wide1", 32'h110, 8'hFF, 8'd1, 1'b1, legal_en); step();

    // Address wraps past top of space
    send(32'hFFFF_FFF8, 8'd1, 3'd3, 2'd1);
    beat("ovf0", 32'hFFFF_FFF8, 8'hFF, 8'd0, 1'b0, legal_en); step();
    beat("ovf1", 32'h0000_0000, 8'hFF, 8'd1, 1'b1, legal_en); step();

    // INCR crossing 4KB
    send(32'h0FF8, 8'd1, 3'd3, 2'd1);
    beat("x4k0", 32'h0FF8, 8'hFF, 8'd0, 1'b0, legal_en); step();
    beat("x4k1", 32'h1000, 8'hFF, 8'd1, 1'b1, legal_en); step();
    expect_idle("x4k");

    // Reset mid-burst at beat 2
    send(32'h5000, 8'd7, 3'd3, 2'd1);
    step();
    step();
    beat("rstm2", 32'h5010, 8'hFF, 8'd2, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_val("rstm_valid", 64'(beat_valid), 64'd0);
    check_val("rstm_ready", 64'(req_ready),  64'd1);
    check_val("rstm_addr",  64'(beat_addr),  64'd0);
    check_val("rstm_idx",   64'(beat_idx),   64'd0);
    step();
    rst = 1'b0;
    step();
    step();
    expect_idle("rstm_after");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
